// File: rtl/uart_tx.sv
// UART transmitter with a small byte FIFO in front of an 8N1 serializer.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | line high, waiting for the FIFO to hold a byte
//   START | start bit (0) on the line
//   DATA  | data bits 0..7 shifted out LSB first, bit_idx tracks position
//   STOP  | stop bit (1); at its end chain into the next frame if queued
module uart_tx #(
   parameter int CLKS_PER_BIT = 87,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          TXD,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  baud, baud_nxt;
   logic [2:0]     bit_idx, bit_idx_nxt;
   logic [7:0]     shreg, shreg_nxt;
   logic           txd_q, txd_nxt;

   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic           push, pop, baud_done, fifo_nonempty;

   assign tx_ready      = (count < DEPTH_C);
   assign push          = tx_valid && tx_ready;
   assign fifo_nonempty = (count != '0);
   assign baud_done     = (baud == BAUD_LAST);

   assign TXD        = txd_q;
   assign busy       = (state != IDLE) || fifo_nonempty;
   assign fifo_count = count;

   // FIFO storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // serializer state register; TXD is registered so the line never glitches
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         txd_q   <= 1'b1;
      end else begin
         state   <= state_nxt;
         baud    <= baud_nxt;
         bit_idx <= bit_idx_nxt;
         shreg   <= shreg_nxt;
         txd_q   <= txd_nxt;
      end
   end

   // next-state, baud timing, FIFO pop and next line level
   always_comb begin
      state_nxt   = state;
      baud_nxt    = baud;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      txd_nxt     = txd_q;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            baud_nxt    = '0;
            bit_idx_nxt = '0;
            txd_nxt     = 1'b1;
            if (fifo_nonempty) begin
               pop       = 1'b1;
               shreg_nxt = mem[rd_ptr];
               state_nxt = START;
               txd_nxt   = 1'b0;
            end
         end
         START: begin
            if (baud_done) begin
               baud_nxt    = '0;
               bit_idx_nxt = '0;
               state_nxt   = DATA;
               txd_nxt     = shreg[0];
               shreg_nxt   = {1'b0, shreg[7:1]};
            end else begin
               baud_nxt = baud + CW'(1);
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_nxt = '0;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
                  txd_nxt   = 1'b1;
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
                  txd_nxt     = shreg[0];
                  shreg_nxt   = {1'b0, shreg[7:1]};
               end
            end else begin
               baud_nxt = baud + CW'(1);
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_nxt = '0;
               // chain straight into the next start bit when a byte is waiting
               if (fifo_nonempty) begin
                  pop       = 1'b1;
                  shreg_nxt = mem[rd_ptr];
                  state_nxt = START;
                  txd_nxt   = 1'b0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               baud_nxt = baud + CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of bytes the transmit FIFO holds; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port tx_data, input, 8 bits: byte offered for transmission.
REQ-006 SHALL have port tx_valid, input, 1 bit: tx_data is valid this cycle.
REQ-007 SHALL have port tx_ready, output, 1 bit: the FIFO can accept a byte this cycle.
REQ-008 SHALL have port TXD, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: high while a frame is on the line or the FIFO is non-empty.
REQ-010 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of bytes currently held in the FIFO.

Function
REQ-011 SHALL use 8N1 framing: one start bit (0), 8 data bits LSB first, one stop bit (1), with no parity.
REQ-012 SHALL hold every bit, including start and stop, on TXD for exactly CLKS_PER_BIT cycles, so a frame lasts 10*CLKS_PER_BIT cycles.
REQ-013 SHALL drive TXD from a register, with no combinational path from any input to TXD.
REQ-014 SHALL drive tx_ready = (fifo_count < FIFO_DEPTH), independent of tx_valid.
REQ-015 SHALL write tx_data into the FIFO at a rising edge where tx_valid && tx_ready, and fifo_count SHALL increment at that same edge.
REQ-016 SHALL ignore tx_valid while tx_ready is low: the byte is not stored and no error flag is raised.
REQ-017 SHALL implement an FSM with states IDLE, START, DATA and STOP.
REQ-018 SHALL, in IDLE with fifo_count > 0, pop the head byte into the shift register at the next edge, enter START and drive TXD=0 from that edge onward.
REQ-019 SHALL, from START, move to DATA after CLKS_PER_BIT cycles, then shift out bits 0..7 one per bit period, using a 3-bit bit index that does not wrap before reaching STOP.
REQ-020 SHALL, from STOP, after CLKS_PER_BIT cycles go to START with a pop if the FIFO is non-empty (no idle cycle between frames), otherwise go to IDLE.
REQ-021 SHALL give a latency of exactly 2 edges from an accepting edge (FIFO empty, FSM in IDLE) to the first cycle TXD=0.
REQ-022 SHALL leave fifo_count unchanged and preserve byte order when a push and a pop occur at the same edge.
REQ-023 SHALL accept no push at an edge where the FIFO is full, even if a pop occurs at that same edge; tx_ready rises on the following cycle.
REQ-024 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-025 SHALL reload the baud counter to 0 at each bit boundary and count up to CLKS_PER_BIT-1.
REQ-026 SHALL drive busy = (state != IDLE) || (fifo_count != 0), combinationally from registers.

Reset
REQ-027 SHALL, while resetn=0, force immediately (asynchronously): TXD=1, state=IDLE, FIFO pointers=0, fifo_count=0, baud counter=0, bit index=0, shift register=0.
REQ-028 SHALL make tx_ready=1 and busy=0 while in reset.
REQ-029 SHALL abort a frame when reset is asserted mid-frame: TXD returns high without waiting for a clock edge, queued bytes are discarded, and no partial frame resumes after release.
REQ-030 SHALL perform the first push or pop no earlier than the first rising edge after resetn goes high.

Verification
REQ-031 SHALL verify single byte (CLKS_PER_BIT=4): push 0x35 -> TXD low 2 edges later, then bit stream 0,1,0,1,0,1,1,0,0,1 at 4 cycles each, 40 cycles total, busy low afterwards.
REQ-032 SHALL verify back-to-back frames: push 0x35, 0x37, 0x38, 0x0D on consecutive cycles -> four frames with no idle gap, in order, 160 cycles total; fifo_count peaks at 3 (or 4 if pushed before the first pop).
REQ-033 SHALL verify the full condition (FIFO_DEPTH=4): hold tx_valid high with bytes 0x00..0x09 while the line is busy -> tx_ready drops at fifo_count=4, only accepted bytes are transmitted, no byte is dropped or duplicated.
REQ-034 SHALL verify reset mid-frame: assert resetn=0 during bit 3 of 0x31 with 2 bytes queued -> TXD=1 at once, fifo_count=0; after release TXD stays high with no frame emitted.
REQ-035 SHALL verify a loopback against the receiver at the default CLKS_PER_BIT=87: send 0x31, 0x34, 0x0D -> the receiver decodes identical bytes.
